multiplier_pipe_hs: RTL
=======================

Name: multiplier_pipe_hs

Overview:
- Parametrised pipelined BW x BW multiplier with valid/ready handshake on input and output.
- Supports a per-transaction signed/unsigned mode and a configurable number of partial-product rows per pipeline stage.
- Sits between operand producers and datapath consumers as the next-generation replacement for the fixed one-row-per-stage array multipliers.
- Throughput is one product per cycle when not stalled.

Parameters:
- BW, 16: operand width in bits; product width is 2*BW.
- RPS, 4: partial-product rows summed per pipeline stage; must divide BW (1..BW).
- LATENCY, BW/RPS: derived constant, not overridable; pipeline stages after the input register.

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands A, B, in_signed are valid.
- in_ready  output  1  block can accept operands this cycle.
- in_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- A  input  BW  multiplicand.
- B  input  BW  multiplier.
- out_valid  output  1  product on out is valid.
- out_ready  input  1  consumer accepts product this cycle.
- out  output  2*BW  product, registered.
- busy  output  1  any pipeline stage (including the input register) holds a valid item.

Behaviour:
- Reset (asynchronous, RESETn low): all stage valid bits = 0, all data registers = 0, out = 0, out_valid = 0, busy = 0, in_ready = 1 combinationally once RESETn is high.
- Reset mid-operation: all in-flight items are discarded; no partial output appears after reset release.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. Stall freezes every stage register, including valid bits (global enable). No bubble collapsing.
- Accept: the input is accepted on a rising edge where in_valid & in_ready. A, B and in_signed are captured into stage 0 with valid = 1. If in_valid = 0 and the pipe is not stalled, stage 0 loads valid = 0.
- Stage s (1..LATENCY):
  - Adds rows (s-1)*RPS .. s*RPS-1 to the incoming partial sum.
  - Registers the result together with A, B, in_signed and the valid bit.
  - The stage LATENCY register drives out / out_valid.
- Latency: an item accepted at edge t has out_valid = 1 after edge t+LATENCY, given no stall. Each stall cycle adds one cycle.
- Row i, unsigned: ({BW'b0,A} & {2BW{B[i]}}) << i.
- Row i, signed: sign-extend A to 2*BW, mask with B[i], shift left by i. Row BW-1 is subtracted (two's-complement negate) instead of added.
- All sums are taken modulo 2^(2*BW); carry-out is discarded.
- Output handshake: out holds stable while out_valid & ~out_ready. The handshake completes on an edge where out_valid & out_ready.
- Simultaneous events: an output transfer and an input accept in the same cycle are allowed (full throughput). in_ready does not depend on in_valid.
- Boundaries:
  - A = 0 or B = 0 -> product 0.
  - Signed -2^(BW-1) x -2^(BW-1) -> 2^(2BW-2), no overflow.
  - Unsigned max x max -> (2^BW-1)^2.
- busy = OR of all stage valid bits.

Optional Feature:
- Macro MULT_ACC_EN.
- When defined:
  - Adds input acc_clear (1 bit, travels with the operands).
  - Adds a 2*BW accumulator register, updated only on an output transfer: acc <= (acc_clear_of_item ? 0 : acc) + product.
  - out presents acc_next, the value after including the current item.
  - Accumulator reset value is 0; wraps modulo 2^(2*BW).
- When undefined: no acc_clear port, no accumulator; out is the raw product.

Decomposition:
- Shared package mult_pkg:
  - BW default.
  - Product-width and latency helper functions.
  - Stage-payload typedef {valid, signed, A, B, psum}.
- One sub-module, multiplier_row_stage:
  - Parameters BW, RPS, STAGE index.
  - Combinationally adds RPS shifted rows to psum.
  - Registers the payload under the shared enable.
  - Instantiated LATENCY times via generate.

Test Plan (BW=16, RPS=4, LATENCY=4):
- Reset release, idle: out = 0, out_valid = 0, in_ready = 1, busy = 0.
- Unsigned 0xFFFF x 0xFFFF accepted at edge 0 -> out = 0xFFFE0001 with out_valid = 1 after edge 4.
- Signed 0x8000 x 0x8000 -> 0x40000000. Signed 0xFFFF x 0x0003 -> 0xFFFFFFFD.
- Back-to-back stream of 20 random operand pairs, out_ready = 1 -> 20 results in order on consecutive cycles, matching the reference model.
- out_ready low for 3 cycles with the pipe full -> in_ready = 0, out is held stable, no loss or duplication; flow resumes in order.
- RESETn pulsed low with 3 items in flight -> outputs are 0 immediately; the in-flight items never emerge.
- With MULT_ACC_EN: items 2x3 (clear = 1), 4x5, 1x1 -> outs 6, 26, 27; next item with clear = 1, 7x7 -> 49.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, latency helper and stage payload for multiplier_pipe_hs
package mult_pkg;

    localparam int MULT_BW = 16;

    function automatic int prod_width(input int bw);
        return 2 * bw;
    endfunction

    function automatic int pipe_latency(input int bw, input int rps);
        return bw / rps;
    endfunction

    // Payload view of one pipeline stage at the default operand width
    typedef struct packed {
        logic                   valid;
        logic                   sgn;
        logic [MULT_BW-1:0]     a;
        logic [MULT_BW-1:0]     b;
        logic [2*MULT_BW-1:0]   psum;
    } stage_t;

endpackage

// File: rtl/multiplier_row_stage.sv
// rtl/multiplier_row_stage.sv - adds RPS partial-product rows and registers the payload (MULT_ACC_EN adds clr)
module multiplier_row_stage
    import mult_pkg::*;
#(
    parameter int BW    = MULT_BW,
    parameter int RPS   = 4,
    parameter int STAGE = 1
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                en,
    input  logic                valid_i,
    input  logic                sgn_i,
`ifdef MULT_ACC_EN
    input  logic                clr_i,
    output logic                clr_o,
`endif
    input  logic [BW-1:0]       a_i,
    input  logic [BW-1:0]       b_i,
    input  logic [2*BW-1:0]     psum_i,
    output logic                valid_o,
    output logic                sgn_o,
    output logic [BW-1:0]       a_o,
    output logic [BW-1:0]       b_o,
    output logic [2*BW-1:0]     psum_o
);

    localparam int PW   = prod_width(BW);
    localparam int BASE = (STAGE - 1) * RPS;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] row;
    logic [BW-1:0] b_sh;
    logic [PW-1:0] sum;

    always_comb begin
        a_ext = sgn_i ? {{BW{a_i[BW-1]}}, a_i} : {{BW{1'b0}}, a_i};
        sum   = psum_i;
        row   = '0;
        b_sh  = '0;
        for (int k = 0; k < RPS; k++) begin
            b_sh = b_i >> (BASE + k);
            row  = (a_ext & {PW{b_sh[0]}}) << (BASE + k);
            // In two's complement the top multiplier bit carries weight -2^(BW-1)
            if (sgn_i && (BASE + k == BW - 1))
                sum = sum - row;
            else
                sum = sum + row;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            valid_o <= 1'b0;
            sgn_o   <= 1'b0;
            a_o     <= '0;
            b_o     <= '0;
            psum_o  <= '0;
`ifdef MULT_ACC_EN
            clr_o   <= 1'b0;
`endif
        end else if (en) begin
            valid_o <= valid_i;
            sgn_o   <= sgn_i;
            a_o     <= a_i;
            b_o     <= b_i;
            psum_o  <= sum;
`ifdef MULT_ACC_EN
            clr_o   <= clr_i;
`endif
        end
    end

endmodule

// File: rtl/multiplier_pipe_hs.sv
// rtl/multiplier_pipe_hs.sv - pipelined BWxBW multiplier with valid/ready handshake; MULT_ACC_EN adds an accumulator
module multiplier_pipe_hs
    import mult_pkg::*;
#(
    parameter int BW  = MULT_BW,
    parameter int RPS = 4
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
`ifdef MULT_ACC_EN
    input  logic                acc_clear,
`endif
    input  logic [BW-1:0]       A,
    input  logic [BW-1:0]       B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*BW-1:0]     out,
    output logic                busy
);

    localparam int LATENCY = pipe_latency(BW, RPS);

    logic [LATENCY:0]               v_q;
    logic [LATENCY:0]               s_q;
    logic [LATENCY:0][BW-1:0]       a_q;
    logic [LATENCY:0][BW-1:0]       b_q;
    logic [LATENCY:0][2*BW-1:0]     p_q;
`ifdef MULT_ACC_EN
    logic [LATENCY:0]               c_q;
    logic                           c0;
`endif

    logic           v0;
    logic           s0;
    logic [BW-1:0]  a0;
    logic [BW-1:0]  b0;
    logic           en;

    // Global enable: a stalled output freezes every stage, bubbles included
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v0 <= 1'b0;
            s0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
`ifdef MULT_ACC_EN
            c0 <= 1'b0;
`endif
        end else if (en) begin
            v0 <= in_valid;
            if (in_valid) begin
                s0 <= in_signed;
                a0 <= A;
                b0 <= B;
`ifdef MULT_ACC_EN
                c0 <= acc_clear;
`endif
            end
        end
    end

    assign v_q[0] = v0;
    assign s_q[0] = s0;
    assign a_q[0] = a0;
    assign b_q[0] = b0;
    assign p_q[0] = '0;
`ifdef MULT_ACC_EN
    assign c_q[0] = c0;
`endif

    for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
        multiplier_row_stage #(
            .BW     (BW),
            .RPS    (RPS),
            .STAGE  (s)
        ) u_stage (
            .CLK     (CLK),
            .RESETn  (RESETn),
            .en      (en),
            .valid_i (v_q[s-1]),
            .sgn_i   (s_q[s-1]),
`ifdef MULT_ACC_EN
            .clr_i   (c_q[s-1]),
            .clr_o   (c_q[s]),
`endif
            .a_i     (a_q[s-1]),
            .b_i     (b_q[s-1]),
            .psum_i  (p_q[s-1]),
            .valid_o (v_q[s]),
            .sgn_o   (s_q[s]),
            .a_o     (a_q[s]),
            .b_o     (b_q[s]),
            .psum_o  (p_q[s])
        );
    end

    assign out_valid = v_q[LATENCY];
    assign busy      = |v_q;

    // Operands are carried to the last stage only for uniformity
    logic unused_tail;
    assign unused_tail = ^{s_q[LATENCY], a_q[LATENCY], b_q[LATENCY]};

`ifdef MULT_ACC_EN
    logic [2*BW-1:0] acc_q;
    logic [2*BW-1:0] acc_next;

    assign acc_next = (c_q[LATENCY] ? '0 : acc_q) + p_q[LATENCY];
    assign out      = acc_next;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            acc_q <= '0;
        else if (out_valid && out_ready)
            acc_q <= acc_next;
    end
`else
    assign out = p_q[LATENCY];
`endif

endmodule
